// File: rtl/pkt_bus_arbiter.sv
// pkt_bus_arbiter: round-robin arbiter that shares one registered packet bus
// among NUM_PORTS sources. Each grant covers one whole packet.
// Optional build macro: PKT_ARB_PROTO_CHK_EN turns on protocol checking. When
// it is set, stray mid/EOP beats seen in IDLE are drained, and SOP/single beats
// that arrive inside a packet are counted as errors.
module pkt_bus_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 512,
    parameter int CTL_W     = 8,
    parameter int PID_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS*CTL_W-1:0]  in_ctl,
    output logic [NUM_PORTS-1:0]        in_rdy,
    output logic [DATA_W-1:0]           out_data,
    output logic [CTL_W-1:0]            out_ctl,
    output logic [PID_W-1:0]            out_pid,
    input  logic                        out_rdy,
    output logic [31:0]                 pkt_cnt,
    output logic                        proto_err,
    output logic [15:0]                 err_cnt
);

    localparam logic [2:0] CTL_SOP    = 3'd1;
    localparam logic [2:0] CTL_EOP    = 3'd3;
    localparam logic [2:0] CTL_SINGLE = 3'd4;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                        state, state_nxt;
    logic [PID_W-1:0]              grant, rr_ptr, pick;
    logic                          req_any;
    logic [NUM_PORTS-1:0][2:0]     ctl_p0;
    logic [2:0]                    ctl_g_p0;
    logic [DATA_W-1:0]             data_g_p0;
    logic                          out_free, accept, pkt_end;
    logic [DATA_W-1:0]             data_p1;
    logic [CTL_W-1:0]              ctl_p1;
    logic [PID_W-1:0]              pid_p1;
    logic                          vld_p1;

    // Control codes outside 0..4 are folded to idle.
    function automatic logic [2:0] norm_ctl(input logic [CTL_W-1:0] c);
        if (c <= CTL_W'(4)) return c[2:0];
        return 3'd0;
    endfunction

    // Round-robin successor of a port index.
    function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] p);
        if (int'(p) == NUM_PORTS - 1) return '0;
        return p + PID_W'(1);
    endfunction

    // Input stage p0: decode every port and search upward from rr_ptr.
    always_comb begin
        req_any = 1'b0;
        pick    = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            ctl_p0[p] = norm_ctl(in_ctl[p*CTL_W +: CTL_W]);
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!req_any &&
                (ctl_p0[PID_W'((int'(rr_ptr) + i) % NUM_PORTS)] == CTL_SOP ||
                 ctl_p0[PID_W'((int'(rr_ptr) + i) % NUM_PORTS)] == CTL_SINGLE)) begin
                req_any = 1'b1;
                pick    = PID_W'((int'(rr_ptr) + i) % NUM_PORTS);
            end
        end
        ctl_g_p0  = ctl_p0[grant];
        data_g_p0 = in_data[int'(grant)*DATA_W +: DATA_W];
    end

    // Handshake and next-state logic; the output register is free when empty or draining.
    always_comb begin
        vld_p1    = (ctl_p1 != '0);
        out_free  = !vld_p1 || out_rdy;
        accept    = (state == XFER) && out_free && (ctl_g_p0 != 3'd0);
        pkt_end   = accept && (ctl_g_p0 == CTL_EOP || ctl_g_p0 == CTL_SINGLE);
        state_nxt = state;
        in_rdy    = '0;
        case (state)
            IDLE: begin
                if (req_any) state_nxt = XFER;
`ifdef PKT_ARB_PROTO_CHK_EN
                for (int p = 0; p < NUM_PORTS; p++)
                    if (ctl_p0[p] == 3'd2 || ctl_p0[p] == CTL_EOP) in_rdy[p] = 1'b1;
`endif
            end
            XFER: begin
                in_rdy[grant] = out_free;
                if (pkt_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage p1: arbitration state, registered beat and packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            pkt_cnt <= '0;
            data_p1 <= '0;
            ctl_p1  <= '0;
            pid_p1  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_any) grant <= pick;
            if (pkt_end) begin
                rr_ptr  <= next_port(grant);
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (accept) begin
                data_p1 <= data_g_p0;
                ctl_p1  <= CTL_W'(ctl_g_p0);
                pid_p1  <= grant;
            end else if (out_free) begin
                ctl_p1  <= '0;
            end
        end
    end

    assign out_data = data_p1;
    assign out_ctl  = ctl_p1;
    assign out_pid  = pid_p1;

`ifdef PKT_ARB_PROTO_CHK_EN
    logic in_pkt, stray, err_now;

    // Error counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) return v;
        return v + 16'd1;
    endfunction

    // Protocol errors: stray mid/EOP beats in IDLE, or a new packet start inside a packet.
    always_comb begin
        stray = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (state == IDLE && (ctl_p0[p] == 3'd2 || ctl_p0[p] == CTL_EOP)) stray = 1'b1;
        err_now = stray ||
                  (accept && in_pkt && (ctl_g_p0 == CTL_SOP || ctl_g_p0 == CTL_SINGLE));
    end

    // Track whether the packet's first beat has gone out, and register error reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt    <= 1'b0;
            proto_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            proto_err <= err_now;
            if (err_now) err_cnt <= sat_inc(err_cnt);
            if (pkt_end) in_pkt <= 1'b0;
            else if (accept) in_pkt <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule
